// File: rtl/iomem_arb_pkg.sv
// Shared types and constants for the two-master iomem arbiter.
// Holds the FSM state encoding, master indices and the forced-completion read value.
package iomem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_arb_rr.sv
// Round-robin winner select for two masters; purely combinational, zero latency.
// No backpressure: on a tie, the master that did not complete last wins.
import iomem_arb_pkg::*;

module iomem_arb_rr (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic winner,
  output logic any_req
);

  assign any_req = valid0 | valid1;
  assign winner  = (valid0 && valid1) ? ~last : (valid1 ? M_DMA : M_CPU);

endmodule

// File: rtl/iomem_arb.sv
// Two-master (CPU=m0, DMA=m1) round-robin arbiter onto one iomem slave port.
// Latency: grant and s_valid one cycle after the first valid in IDLE; one IDLE cycle between grants.
// Backpressure: owner waits on s_ready; optional forced completion with IOMEM_ARB_TIMEOUT_EN.
import iomem_arb_pkg::*;

module iomem_arb #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  gnt,
  output logic        timeout_err
);

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last, last_nxt;
  logic   win, any_req;
  logic   busy, own_valid, tmo;

  iomem_arb_rr u_rr (
    .valid0  (m0_valid),
    .valid1  (m1_valid),
    .last    (last),
    .winner  (win),
    .any_req (any_req)
  );

  assign busy      = (state == BUSY);
  assign own_valid = owner ? m1_valid : m0_valid;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Counts BUSY cycles already elapsed; held at zero in IDLE so every grant starts fresh.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   tmo_cnt <= '0;
    else if (!busy) tmo_cnt <= '0;
    else           tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign tmo = busy && !s_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= M_CPU;
      last  <= M_DMA;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = s_rdata;
    m1_rdata    = s_rdata;
    gnt         = 2'b00;
    timeout_err = tmo;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = win;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        gnt     = (owner == M_DMA) ? 2'b10 : 2'b01;
        s_valid = own_valid & ~tmo;
        s_addr  = (owner == M_DMA) ? m1_addr  : m0_addr;
        s_wdata = (owner == M_DMA) ? m1_wdata : m0_wdata;
        s_wstrb = (owner == M_DMA) ? m1_wstrb : m0_wstrb;
        if (s_ready || tmo) begin
          m0_ready  = (owner == M_CPU);
          m1_ready  = (owner == M_DMA);
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (!own_valid) begin
          // Owner withdrew its request: drop the grant but keep the tie-break history.
          state_nxt = IDLE;
        end
        if (tmo) begin
          if (owner == M_DMA) m1_rdata = TIMEOUT_RDATA;
          else                m0_rdata = TIMEOUT_RDATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iomem_arb.sv
// Directed bench for iomem_arb: read/ready data is scoreboarded per master, grants and forwarding checked inline.
module tb_iomem_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  gnt;
  logic        timeout_err;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int rdy0_cnt = 0, rdy1_cnt = 0, terr_cnt = 0;
  int r0_save, r1_save;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  iomem_arb #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .gnt(gnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Caller sits one step after a BUSY edge; returns one step into the following IDLE cycle.
  task automatic finish_xfer(input logic [31:0] rd);
    s_ready = 1'b1;
    s_rdata = rd;
    tick();
    s_ready = 1'b0;
  endtask

  // Completion monitor: every ready pulse must match the oldest expected rdata for that master.
  always @(negedge clk) begin
    if (m0_ready === 1'b1) begin
      rdy0_cnt++;
      if (q0.size() == 0) chk("m0_spurious_ready", {31'b0, m0_ready}, 32'd0);
      else                chk("m0_rdata", m0_rdata, q0.pop_front());
    end
    if (m1_ready === 1'b1) begin
      rdy1_cnt++;
      if (q1.size() == 0) chk("m1_spurious_ready", {31'b0, m1_ready}, 32'd0);
      else                chk("m1_rdata", m1_rdata, q1.pop_front());
    end
    if (timeout_err === 1'b1) terr_cnt++;
  end

  initial begin
    int found;
    int hold;
    resetn   = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready  = 1'b1; s_rdata = 32'h55AA_33CC;
    repeat (2) tick();
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_s_wstrb", {28'b0, s_wstrb}, 32'd0);
    chk("rst_gnt", {30'b0, gnt}, 32'd0);
    chk("rst_readys", {30'b0, m1_ready, m0_ready}, 32'd0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h55AA_33CC);
    m0_valid = 1'b0; s_ready = 1'b0; resetn = 1'b1;
    tick();

    // Single read with s_ready two cycles after s_valid
    m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
    q0.push_back(32'h1234_5678);
    #1 chk("rd_idle_gnt", {30'b0, gnt}, 32'd0);
    chk("rd_idle_s_valid", {31'b0, s_valid}, 32'd0);
    tick();
    chk("rd_gnt", {30'b0, gnt}, 32'd1);
    chk("rd_s_valid", {31'b0, s_valid}, 32'd1);
    chk("rd_s_addr", s_addr, 32'h0300_0000);
    tick();
    chk("rd_wait_ready", {31'b0, m0_ready}, 32'd0);
    tick();
    finish_xfer(32'h1234_5678);
    m0_valid = 1'b0;
    #1 chk("rd_gnt_after", {30'b0, gnt}, 32'd0);
    chk("rd_m0_pulses", rdy0_cnt, 32'd1);
    chk("rd_m1_pulses", rdy1_cnt, 32'd0);

    // Tie after reset: m0, then m1, then m0 again
    resetn = 1'b0; #1 resetn = 1'b1;
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    q0.push_back(32'h0000_00D0); q1.push_back(32'h0000_00D1);
    tick();
    chk("tie1_gnt", {30'b0, gnt}, 32'd1);
    finish_xfer(32'h0000_00D0);
    m0_valid = 1'b0;
    #1 chk("tie_gap_gnt", {30'b0, gnt}, 32'd0);
    tick();
    chk("tie2_gnt", {30'b0, gnt}, 32'd2);
    chk("tie2_s_addr", s_addr, 32'h0000_0200);
    finish_xfer(32'h0000_00D1);
    m0_valid = 1'b1;
    q0.push_back(32'h0000_00D2);
    tick();
    chk("tie3_gnt", {30'b0, gnt}, 32'd1);
    finish_xfer(32'h0000_00D2);
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Write forwarding from m1
    m1_valid = 1'b1; m1_addr = 32'h0300_0004; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
    q1.push_back(32'h0000_0000);
    tick();
    chk("wr_gnt", {30'b0, gnt}, 32'd2);
    chk("wr_s_addr", s_addr, 32'h0300_0004);
    chk("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("wr_s_wstrb", {28'b0, s_wstrb}, 32'h3);
    finish_xfer(32'h0000_0000);
    m1_valid = 1'b0; m1_wstrb = 4'h0;

    // Abort: m0 drops valid one cycle into BUSY; last must stay at m1
    r0_save = rdy0_cnt; r1_save = rdy1_cnt;
    m0_valid = 1'b1; m0_addr = 32'h0000_0010;
    tick();
    chk("ab_gnt", {30'b0, gnt}, 32'd1);
    tick();
    m0_valid = 1'b0;
    #1 chk("ab_s_valid", {31'b0, s_valid}, 32'd0);
    tick();
    chk("ab_idle_gnt", {30'b0, gnt}, 32'd0);
    chk("ab_no_pulse", rdy0_cnt + rdy1_cnt, r0_save + r1_save);
    m0_valid = 1'b1; m1_valid = 1'b1;
    q0.push_back(32'h0000_00D3); q1.push_back(32'h0000_00D4);
    tick();
    chk("ab_tie_gnt", {30'b0, gnt}, 32'd1);
    finish_xfer(32'h0000_00D3);
    m0_valid = 1'b0;
    tick();
    chk("ab_next_gnt", {30'b0, gnt}, 32'd2);
    finish_xfer(32'h0000_00D4);
    m1_valid = 1'b0;

    // Reset while m0 owns the slave, with s_ready arriving at the same time
    r0_save = rdy0_cnt;
    m0_valid = 1'b1;
    tick();
    chk("mr_gnt", {30'b0, gnt}, 32'd1);
    resetn = 1'b0; s_ready = 1'b1;
    #1 chk("mr_s_valid", {31'b0, s_valid}, 32'd0);
    chk("mr_gnt_rst", {30'b0, gnt}, 32'd0);
    chk("mr_readys", {30'b0, m1_ready, m0_ready}, 32'd0);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0; resetn = 1'b1;
    tick();
    chk("mr_no_pulse", rdy0_cnt, r0_save);

    // Slave never answers
    m1_valid = 1'b1; m1_addr = 32'h0300_0008; m1_wstrb = 4'h0;
    s_rdata = 32'h0BAD_F00D;
`ifdef IOMEM_ARB_TIMEOUT_EN
    q1.push_back(32'hDEAD_BEEF);
    tick();
    found = -1;
    for (int i = 0; i < 30; i++) begin
      if (m1_ready === 1'b1) begin
        found = i;
        chk("tmo_err", {31'b0, timeout_err}, 32'd1);
        chk("tmo_s_valid", {31'b0, s_valid}, 32'd0);
        break;
      end
      tick();
    end
    tick();
    m1_valid = 1'b0;
    chk("tmo_cycle", found, 32'd8);
    chk("tmo_err_pulses", terr_cnt, 32'd1);
    tick();
    chk("tmo_idle_gnt", {30'b0, gnt}, 32'd0);
`else
    tick();
    hold = 0;
    for (int i = 0; i < 120; i++) begin
      if (s_valid === 1'b1 && timeout_err === 1'b0 && gnt === 2'b10) hold++;
      tick();
    end
    chk("hold_s_valid", hold, 32'd120);
    m1_valid = 1'b0;
    tick();
    chk("hold_abort_gnt", {30'b0, gnt}, 32'd0);
    chk("hold_err_pulses", terr_cnt, 32'd0);
`endif

    tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
